deserializer: RTL



---
 rtl/deserializer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel receive stage: rebuilds 16-bit words (bit 0 first) framed by
// the enable rising edge or an in-band sync word, and queues them in a 2-entry FIFO.
module deserializer #(
    parameter logic [15:0] SYNC_WORD = 16'hA5C3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        din,
    input  logic        align_en,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        locked,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [4:0]  fill;
    logic [15:0] sr;
    logic        mode;

    logic [15:0] mem [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;

    logic [15:0] sr_next;
    logic        push;
    logic        pop;
    logic        accept;
    logic        drop;
    logic        head_next;
    logic [1:0]  count_next;

    // sr doubles as the word assembler in LOCKED: after 16 shifts sr[k] holds bit k
    always_comb begin
        sr_next    = {din, sr[15:1]};
        push       = enable && (state == LOCKED) && (cnt == 4'd15) &&
                     !(mode && (sr_next == SYNC_WORD));
        pop        = (count != 2'd0) && dout_ready;
        accept     = push && ((count != 2'd2) || pop);
        drop       = push && !accept;
        head_next  = pop ? ~head : head;
        count_next = count + {1'b0, accept} - {1'b0, pop};
    end

    assign dout_valid = (count != 2'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            fill     <= '0;
            sr       <= '0;
            mode     <= 1'b0;
            locked   <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
            head     <= 1'b0;
            tail     <= 1'b0;
            count    <= '0;
            dout     <= '0;
            overflow <= 1'b0;
        end else begin
            if (!enable) begin
                state  <= IDLE;
                cnt    <= '0;
                fill   <= '0;
                sr     <= '0;
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        mode <= align_en;
                        sr   <= sr_next;
                        if (align_en) begin
                            state <= HUNT;
                            fill  <= 5'd1;
                        end else begin
                            state  <= LOCKED;
                            cnt    <= 4'd1;
                            locked <= 1'b1;
                        end
                    end
                    HUNT: begin
                        // fill >= 15 here means the current bit is at least the 16th taken
                        if ((sr_next == SYNC_WORD) && (fill >= 5'd15)) begin
                            state  <= LOCKED;
                            cnt    <= '0;
                            fill   <= '0;
                            sr     <= '0;
                            locked <= 1'b1;
                        end else begin
                            sr <= sr_next;
                            if (fill != 5'd16)
                                fill <= fill + 5'd1;
                        end
                    end
                    LOCKED: begin
                        sr  <= sr_next;
                        cnt <= cnt + 4'd1;
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end

            if (accept) begin
                mem[tail] <= sr_next;
                tail      <= ~tail;
            end
            head  <= head_next;
            count <= count_next;
            if (drop)
                overflow <= 1'b1;
            // dout tracks the next head; when the new head is the slot being written, bypass
            if (count_next != 2'd0)
                dout <= (accept && (head_next == tail)) ? sr_next : mem[head_next];
        end
    end

endmodule
